// File: rtl/mem_access.sv
// rtl/mem_access.sv - MIPS memory-access stage with bus master and MEM/WB register
//
// Purpose: performs loads and stores for the 5-stage pipeline over a single
// request/acknowledge data bus. It stalls the front of the pipeline while a
// transfer is outstanding. It also registers the GPR and HI/LO write-back
// payload for the write-back stage.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   aluop_i             ALU op from EX/MEM; only load/store ops touch the bus
//   wd_i, wreg_i        destination GPR and its write enable
//   wdata_i             EX result, forwarded for non-load ops
//   hi_i, lo_i, whilo_i HI/LO values and their write enable
//   mem_addr_i          effective byte address
//   store_data_i        rt value for stores
//   wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o   registered write-back payload
//   stallreq_o          combinational stall request to pipeline control
//   bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o   registered bus request
//   bus_rdata_i, bus_ack_i                        bus response (ack is a 1-cycle pulse)

module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_start;
  logic        w_done;
  logic        w_is_load;
  logic        w_is_store;
  logic [3:0]  w_sel;
  logic [31:0] w_bus_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Fields captured at request time; the EX/MEM latch is frozen while
  // BUSY, but capturing keeps the result independent of upstream behaviour.
  logic [7:0]  r_op;
  logic [1:0]  r_lane;
  logic [4:0]  r_wd;
  logic        r_wreg;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_whilo;

  // Op decode, big-endian lane select and store data replication.
  always_comb begin
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_sel       = 4'b1111;
    w_bus_wdata = store_data_i;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        w_sel       = 4'b1000 >> mem_addr_i[1:0];
        w_bus_wdata = {4{store_data_i[7:0]}};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        w_sel       = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        w_bus_wdata = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: w_is_load  = 1'b1;
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:                         w_is_store = 1'b1;
      default: ;
    endcase
  end

  // Next state and stall request.
  always_comb begin
    w_next_state = r_state;
    stallreq_o   = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_load || w_is_store) begin
          stallreq_o   = 1'b1;
          w_start      = 1'b1;
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        // Dropping the stall in the ack cycle lets EX/MEM advance on the
        // same edge that retires this transfer.
        stallreq_o = !bus_ack_i;
        if (bus_ack_i) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Load data extraction and extension, using the captured op and lane.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = bus_rdata_i[31:24];
      2'd1:    w_byte = bus_rdata_i[23:16];
      2'd2:    w_byte = bus_rdata_i[15:8];
      default: w_byte = bus_rdata_i[7:0];
    endcase
    w_half = r_lane[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (r_op)
      EXE_LB_OP:  w_ext = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: w_ext = {24'h0, w_byte};
      EXE_LH_OP:  w_ext = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: w_ext = {16'h0, w_half};
      EXE_LW_OP:  w_ext = bus_rdata_i;
      default:    w_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_o        <= 5'd0;
      wreg_o      <= 1'b0;
      wdata_o     <= 32'h0;
      hi_o        <= 32'h0;
      lo_o        <= 32'h0;
      whilo_o     <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_sel_o   <= 4'h0;
      bus_wdata_o <= 32'h0;
      r_op        <= 8'h0;
      r_lane      <= 2'd0;
      r_wd        <= 5'd0;
      r_wreg      <= 1'b0;
      r_hi        <= 32'h0;
      r_lo        <= 32'h0;
      r_whilo     <= 1'b0;
    end else if (w_start) begin
      bus_req_o   <= 1'b1;
      bus_we_o    <= w_is_store;
      bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
      bus_sel_o   <= w_sel;
      bus_wdata_o <= w_bus_wdata;
      r_op        <= aluop_i;
      r_lane      <= mem_addr_i[1:0];
      r_wd        <= wd_i;
      r_wreg      <= wreg_i;
      r_hi        <= hi_i;
      r_lo        <= lo_i;
      r_whilo     <= whilo_i;
      // Bubble to write-back until the transfer completes.
      wd_o        <= 5'd0;
      wreg_o      <= 1'b0;
      wdata_o     <= 32'h0;
      hi_o        <= 32'h0;
      lo_o        <= 32'h0;
      whilo_o     <= 1'b0;
    end else if (w_done) begin
      bus_req_o   <= 1'b0;
      wd_o        <= r_wd;
      wreg_o      <= r_wreg;
      wdata_o     <= w_ext;
      hi_o        <= r_hi;
      lo_o        <= r_lo;
      whilo_o     <= r_whilo;
    end else if (r_state == S_IDLE) begin
      wd_o        <= wd_i;
      wreg_o      <= wreg_i;
      wdata_o     <= wdata_i;
      hi_o        <= hi_i;
      lo_o        <= lo_i;
      whilo_o     <= whilo_i;
    end
  end

endmodule
